hist2d_readout: RTL and testbench

//  Reader side of the hist2d bin-update interface. Captures each bin_found update (i/q bin coord + count) into a

---
 rtl/hist_pkg.sv | 22 ++
 rtl/hist_bin_ram.sv | 27 ++
 rtl/hist2d_readout.sv | 229 ++++++++++++++++++++++
 tb/tb_hist2d_readout.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared types and constants for the hist2d readout block.
package hist_pkg;

  // Readout FSM states.
  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_HDR,
    ST_RD,
    ST_HI,
    ST_LO,
    ST_CSUM,
    ST_DONE
  } state_t;

  // Frame start byte.
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Index into the 3-byte frame header (start byte, i count, q count).
  typedef logic [1:0] hdr_idx_t;

endpackage

// File: rtl/hist_bin_ram.sv
// Shadow bin RAM: one write port, one read port with registered,
// read-enabled output (read-before-write on address collision).
module hist_bin_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Write lands and read samples the old contents on the same edge.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hist2d_readout.sv
// Reader side of the hist2d bin-update interface: mirrors bin updates into
// a shadow RAM and streams the active grid as a byte frame on request.
// Define HIST_READOUT_CHECKSUM_EN to append an XOR checksum byte.
module hist2d_readout
  import hist_pkg::*;
#(
  parameter int          I_BITS = 4,
  parameter int          Q_BITS = 4,
  parameter int          CNT_W  = 16,
  parameter logic [7:0]  HDR    = HDR_BYTE
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             bin_found,
  input  logic [7:0]       i_bin_coord,
  input  logic [7:0]       q_bin_coord,
  input  logic [CNT_W-1:0] bin_val,
  input  logic [7:0]       i_bin_num,
  input  logic [7:0]       q_bin_num,
  input  logic             clear_req,
  input  logic             dump_start,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             dump_done,
  output logic             drop_flag
);

  localparam int         AW    = I_BITS + Q_BITS;
  localparam logic [8:0] I_MAX = 9'(1 << I_BITS);
  localparam logic [8:0] Q_MAX = 9'(1 << Q_BITS);

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  hdr_idx_t          hdr_idx_q, hdr_idx_d;
  logic [I_BITS-1:0] i_q, i_d;
  logic [Q_BITS-1:0] q_q, q_d;
  logic [8:0]        i_n_q, i_n_d, q_n_q, q_n_d;
  logic [7:0]        csum_q, csum_d;
  logic              drop_q, drop_d;
  logic              upd_we_q, upd_we_d;
  logic [AW-1:0]     upd_addr_q, upd_addr_d;
  logic [CNT_W-1:0]  upd_val_q, upd_val_d;

  logic              ram_we, ram_re, sweep_adv, accept, in_range;
  logic              last_i, last_q;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [CNT_W-1:0]  ram_wdata, ram_rdata;
  logic [8:0]        i_n_in, q_n_in, i_n_clamp, q_n_clamp;

  assign accept    = tx_valid && tx_ready;
  assign in_range  = ((i_bin_coord >> I_BITS) == 8'd0) && ((q_bin_coord >> Q_BITS) == 8'd0);
  assign last_i    = (9'(i_q) == i_n_q - 9'd1);
  assign last_q    = (9'(q_q) == q_n_q - 9'd1);
  assign i_n_in    = {1'b0, i_bin_num};
  assign q_n_in    = {1'b0, q_bin_num};
  assign i_n_clamp = (i_n_in == 9'd0 || i_n_in > I_MAX) ? I_MAX : i_n_in;
  assign q_n_clamp = (q_n_in == 9'd0 || q_n_in > Q_MAX) ? Q_MAX : q_n_in;
  assign drop_flag = drop_q;

  // Register state, counters and the pending update.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      addr_q     <= '0;
      hdr_idx_q  <= '0;
      i_q        <= '0;
      q_q        <= '0;
      i_n_q      <= '0;
      q_n_q      <= '0;
      csum_q     <= '0;
      drop_q     <= 1'b0;
      upd_we_q   <= 1'b0;
      upd_addr_q <= '0;
      upd_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hdr_idx_q  <= hdr_idx_d;
      i_q        <= i_d;
      q_q        <= q_d;
      i_n_q      <= i_n_d;
      q_n_q      <= q_n_d;
      csum_q     <= csum_d;
      drop_q     <= drop_d;
      upd_we_q   <= upd_we_d;
      upd_addr_q <= upd_addr_d;
      upd_val_q  <= upd_val_d;
    end
  end

  // Single write port: a pending update takes it; the clear sweep stalls
  // unless the update hits the sweep address, in which case it counts as written.
  always_comb begin
    ram_we    = upd_we_q || (state_q == ST_CLEAR);
    ram_waddr = upd_we_q ? upd_addr_q : addr_q;
    ram_wdata = upd_we_q ? upd_val_q : '0;
    sweep_adv = (state_q == ST_CLEAR) && (!upd_we_q || (upd_addr_q == addr_q));
  end

  // Next-state, counters, checksum, update capture and drop flag.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hdr_idx_d  = hdr_idx_q;
    i_d        = i_q;
    q_d        = q_q;
    i_n_d      = i_n_q;
    q_n_d      = q_n_q;
    csum_d     = csum_q;
    drop_d     = drop_q;
    upd_we_d   = bin_found && in_range;
    upd_addr_d = {q_bin_coord[Q_BITS-1:0], i_bin_coord[I_BITS-1:0]};
    upd_val_d  = bin_val;
    case (state_q)
      ST_CLEAR: begin
        if (sweep_adv) begin
          addr_d = addr_q + AW'(1);
          if (addr_q == '1) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          addr_d  = '0;
          drop_d  = 1'b0;
        end else if (dump_start) begin
          state_d   = ST_HDR;
          hdr_idx_d = '0;
          i_n_d     = i_n_clamp;
          q_n_d     = q_n_clamp;
          csum_d    = '0;
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (hdr_idx_q != 2'd0) csum_d = csum_q ^ tx_data;
          if (hdr_idx_q == 2'd2) begin
            state_d = ST_RD;
            i_d     = '0;
            q_d     = '0;
          end else begin
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
      end
      ST_RD: state_d = ST_HI;
      ST_HI: begin
        if (accept) begin
          csum_d  = csum_q ^ tx_data;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          csum_d  = csum_q ^ tx_data;
          state_d = ST_RD;
          if (last_i) begin
            i_d = '0;
            if (last_q) begin
`ifdef HIST_READOUT_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              state_d = ST_DONE;
`endif
            end else begin
              q_d = q_q + Q_BITS'(1);
            end
          end else begin
            i_d = i_q + I_BITS'(1);
          end
        end
      end
      ST_CSUM: if (accept) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase
    if (bin_found && !in_range) drop_d = 1'b1;
  end

  // Outputs decoded from registered state; count bytes come from the RAM
  // read register, which only reloads in RD so it stays stable through HI/LO.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    busy      = (state_q != ST_IDLE);
    dump_done = (state_q == ST_DONE);
    ram_re    = (state_q == ST_RD);
    ram_raddr = {q_q, i_q};
    case (state_q)
      ST_HDR: begin
        tx_valid = 1'b1;
        case (hdr_idx_q)
          2'd0:    tx_data = HDR;
          2'd1:    tx_data = i_n_q[7:0];
          default: tx_data = q_n_q[7:0];
        endcase
      end
      ST_HI: begin
        tx_valid = 1'b1;
        tx_data  = ram_rdata[CNT_W-1:8];
      end
      ST_LO: begin
        tx_valid = 1'b1;
        tx_data  = ram_rdata[7:0];
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
      end
      default: ;
    endcase
  end

  hist_bin_ram #(
    .AW (AW),
    .DW (CNT_W)
  ) u_ram (
    .clk   (clk100),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_hist2d_readout.sv
// Scoreboard bench for hist2d_readout: frames predicted from a bin-array model.
module tb_hist2d_readout;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic        bin_found = 1'b0;
  logic [7:0]  i_bin_coord = '0;
  logic [7:0]  q_bin_coord = '0;
  logic [15:0] bin_val = '0;
  logic [7:0]  i_bin_num = '0;
  logic [7:0]  q_bin_num = '0;
  logic        clear_req = 1'b0;
  logic        dump_start = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        dump_done;
  logic        drop_flag;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int ready_mode = 0;

  logic [15:0] model [16][16];
  logic [7:0]  exp_q [$];
  bit          exp_drop = 1'b0;

  hist2d_readout #(
    .I_BITS (4),
    .Q_BITS (4),
    .CNT_W  (16),
    .HDR    (8'hA5)
  ) dut (
    .clk100      (clk100),
    .rst         (rst),
    .bin_found   (bin_found),
    .i_bin_coord (i_bin_coord),
    .q_bin_coord (q_bin_coord),
    .bin_val     (bin_val),
    .i_bin_num   (i_bin_num),
    .q_bin_num   (q_bin_num),
    .clear_req   (clear_req),
    .dump_start  (dump_start),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .dump_done   (dump_done),
    .drop_flag   (drop_flag)
  );

  always #5 clk100 = ~clk100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int q = 0; q < 16; q++)
      for (int i = 0; i < 16; i++)
        model[q][i] = '0;
  endtask

  // Sink ready patterns: always ready, 3-on/3-off, random.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk100);
      #1;
      ph++;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ((ph / 3) % 2) == 0;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted byte, checks hold behaviour.
  initial begin
    bit         stall;
    logic [7:0] stall_data;
    logic [7:0] e;
    stall = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk100);
      if (rst) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(stall_data));
      end
      if (dump_done) done_cnt++;
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_byte: got %0h expected no byte at %0t", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", 32'(tx_data), 32'(e));
        end
      end
      stall      = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  task automatic upd(input int i, input int q, input logic [15:0] v);
    @(posedge clk100);
    #1;
    bin_found   = 1'b1;
    i_bin_coord = 8'(i);
    q_bin_coord = 8'(q);
    bin_val     = v;
    if (i < 16 && q < 16) model[q][i] = v;
    else exp_drop = 1'b1;
    @(posedge clk100);
    #1;
    bin_found = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk100);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // Build expected frame from the model, start a dump and wait for it to end.
  task automatic do_dump(input int in_raw, input int qn_raw, input bit double_start);
    int         in_n, qn_n, d0, n;
    logic [7:0] cs;
    in_n = (in_raw == 0 || in_raw > 16) ? 16 : in_raw;
    qn_n = (qn_raw == 0 || qn_raw > 16) ? 16 : qn_raw;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(in_n));
    exp_q.push_back(8'(qn_n));
    cs = 8'(in_n) ^ 8'(qn_n);
    for (int q = 0; q < qn_n; q++)
      for (int i = 0; i < in_n; i++) begin
        exp_q.push_back(model[q][i][15:8]);
        exp_q.push_back(model[q][i][7:0]);
        cs = cs ^ model[q][i][15:8] ^ model[q][i][7:0];
      end
`ifdef HIST_READOUT_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    d0 = done_cnt;
    @(posedge clk100);
    #1;
    i_bin_num  = 8'(in_raw);
    q_bin_num  = 8'(qn_raw);
    dump_start = 1'b1;
    @(posedge clk100);
    #1;
    dump_start = 1'b0;
    if (double_start) begin
      repeat (10) @(posedge clk100);
      #1;
      dump_start = 1'b1;
      @(posedge clk100);
      #1;
      dump_start = 1'b0;
    end
    n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk100);
      n++;
    end
    repeat (20) @(negedge clk100);
    check("frame_complete", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("idle_after_dump", 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n, base, d0;
    model_zero();
    #2;
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_dump_done", 32'(dump_done), 32'd0);
    check("rst_drop_flag", 32'(drop_flag), 32'd0);

    @(posedge clk100);
    #1;
    rst = 1'b0;
    n = 0;
    @(negedge clk100);
    while (busy && n < 1000) begin
      n++;
      @(negedge clk100);
    end
    check("clear_cycles", 32'(n), 32'd256);

    // Zero grid, then a single update.
    do_dump(2, 2, 1'b0);
    upd(1, 0, 16'h0102);
    do_dump(2, 2, 1'b0);

    // Stalling sink.
    ready_mode = 1;
    do_dump(2, 2, 1'b0);
    do_dump(3, 5, 1'b0);

    // Out-of-range update is dropped and flagged.
    ready_mode = 0;
    upd(20, 3, 16'hBEEF);
    upd(2, 17, 16'hDEAD);
    @(negedge clk100);
    check("drop_set", 32'(drop_flag), 32'(exp_drop));
    do_dump(4, 4, 1'b0);

    // Clear zeroes RAM and drop flag.
    @(posedge clk100);
    #1;
    clear_req = 1'b1;
    @(posedge clk100);
    #1;
    clear_req = 1'b0;
    model_zero();
    exp_drop = 1'b0;
    @(negedge clk100);
    check("drop_cleared", 32'(drop_flag), 32'd0);
    check("busy_in_clear", 32'(busy), 32'd1);
    wait_idle("clear_done");
    do_dump(4, 4, 1'b0);

    // Random updates, dims (including 0 and >max) and sink behaviour.
    ready_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 12; k++)
        upd(int'($urandom_range(0, 17)), int'($urandom_range(0, 17)), 16'($urandom));
      @(negedge clk100);
      check("drop_rand", 32'(drop_flag), 32'(exp_drop));
      do_dump(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 1'b0);
    end

    // dump_start while busy is ignored.
    do_dump(16, 16, 1'b1);

    // clear_req and dump_start together: clear only.
    ready_mode = 0;
    d0 = done_cnt;
    @(posedge clk100);
    #1;
    clear_req  = 1'b1;
    dump_start = 1'b1;
    @(posedge clk100);
    #1;
    clear_req  = 1'b0;
    dump_start = 1'b0;
    model_zero();
    exp_drop = 1'b0;
    wait_idle("clear_dump_idle");
    repeat (5) @(negedge clk100);
    check("clear_wins_no_done", 32'(done_cnt - d0), 32'd0);
    check("clear_wins_drop", 32'(drop_flag), 32'd0);

    // Reset after the 5th byte of a dump.
    upd(3, 3, 16'h1234);
    upd(0, 1, 16'h5678);
    begin
      exp_q.push_back(8'hA5);
      @(posedge clk100);
      #1;
      i_bin_num  = 8'd4;
      q_bin_num  = 8'd4;
      dump_start = 1'b1;
      base = acc_cnt;
      for (int k = 0; k < 4; k++) exp_q.push_back(k == 0 ? 8'd4 : (k == 1 ? 8'd4 : 8'd0));
      @(posedge clk100);
      #1;
      dump_start = 1'b0;
      n = 0;
      while (acc_cnt < base + 5 && n < 200) begin
        @(negedge clk100);
        n++;
      end
      check("five_bytes", 32'(acc_cnt - base), 32'd5);
      @(posedge clk100);
      #1;
      rst = 1'b1;
      #1;
      check("abort_tx_valid", 32'(tx_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd1);
      exp_q.delete();
      model_zero();
      exp_drop = 1'b0;
      repeat (3) @(posedge clk100);
      #1;
      rst = 1'b0;
    end
    wait_idle("post_rst_clear");
    check("post_rst_drop", 32'(drop_flag), 32'd0);
    do_dump(4, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
